// File: rtl/fifo_stream_reader_if.sv
// Purpose: FIFO read-port and valid/ready stream bundle for fifo_stream_reader.
// Signals:
//   fifo_empty, fifo_data  - FIFO empty flag and registered read data (1-cycle latency)
//   fifo_rd_en             - FIFO read strobe
//   m_valid, m_ready       - stream handshake
//   m_data, m_last         - stream payload and end-of-burst marker
// Modports: master = the reader (drives rd_en and the stream), slave = FIFO/consumer side.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Purpose: read-side controller for a synchronous FIFO with 1-cycle registered read
//   data. Pops words while downstream has room, presents them on a valid/ready
//   stream, marks the last beat of each fixed-length burst and counts bursts.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   i_en         - enable for issuing new FIFO reads
//   o_burst_cnt  - completed bursts, wraps modulo 2^CNT_WIDTH
//   bus          - FIFO read port + stream master (fifo_stream_reader_if.master)
// fifo_rd_en is combinational (m_ready -> fifo_rd_en) so a full-rate stream needs
// only a 2-entry buffer. bus must be instantiated with the same DATA_WIDTH.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_burst_cnt,
  fifo_stream_reader_if.master bus
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [CNT_WIDTH-1:0]  r_burst_cnt;

  logic                  w_pop;
  logic                  w_rd_en;
  logic [2:0]            w_committed;
  logic [1:0]            w_occ_kept;

  // Read issue: only request when the word (plus any in flight) still fits after this pop.
  always_comb begin
    w_pop       = (r_occ != 2'd0) && bus.m_ready;
    w_committed = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
    w_occ_kept  = r_occ - 2'(w_pop);
    w_rd_en     = !rst && i_en && !bus.fifo_empty && (w_committed < 3'd2);
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = (r_occ != 2'd0);
  assign bus.m_data     = r_head;
  assign bus.m_last     = (r_occ != 2'd0) && (r_beat_cnt == LAST_BEAT);
  assign o_burst_cnt    = r_burst_cnt;

  // Two-entry in-order buffer; the landing word goes to whichever slot is first free after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_rd_en;
      r_occ      <= w_occ_kept + 2'(r_inflight);
      if (w_pop && (r_occ == 2'd2)) begin
        r_head <= r_tail;
      end
      if (r_inflight) begin
        if (w_occ_kept == 2'd0) begin
          r_head <= bus.fifo_data;
        end else begin
          r_tail <= bus.fifo_data;
        end
      end
    end
  end

  // Burst tracking: beat position advances only on accepted beats, so underflow just pauses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
    end else if (w_pop) begin
      if (r_beat_cnt == LAST_BEAT) begin
        r_beat_cnt  <= '0;
        r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
      end else begin
        r_beat_cnt  <= r_beat_cnt + BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two instances (BURST_LEN=4 and BURST_LEN=1) share
// one pushed word log, each with its own FIFO read pointer. A per-cycle checker
// tracks the expected stream from the word log and beat counts; directed phases
// pin latency, backpressure, underflow, enable gating and reset with literals.
module tb_fifo_stream_reader;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic en    = 1'b0;
  logic ready = 1'b0;
  logic [15:0] bc0, bc1;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus0 ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus1 ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .i_en(en), .o_burst_cnt(bc0), .bus(bus0));

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .i_en(en), .o_burst_cnt(bc1), .bus(bus1));

  // FIFO model: shared word log, separate read pointers, registered read data.
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rp0 = 0, rp1 = 0;
  logic [DW-1:0] fd0 = '0, fd1 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rp0 <= wr_ptr;
    end else if (bus0.fifo_rd_en) begin
      fd0 <= mem[rp0[7:0]];
      rp0 <= rp0 + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rp1 <= wr_ptr;
    end else if (bus1.fifo_rd_en) begin
      fd1 <= mem[rp1[7:0]];
      rp1 <= rp1 + 1;
    end
  end

  assign bus0.fifo_empty = (rp0 == wr_ptr);
  assign bus0.fifo_data  = fd0;
  assign bus0.m_ready    = ready;
  assign bus1.fifo_empty = (rp1 == wr_ptr);
  assign bus1.fifo_data  = fd1;
  assign bus1.m_ready    = ready;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle model check for both instances.
  int idx [2];
  int beats [2];
  int reads [2];
  int pops [2];
  logic stall [2];
  logic [DW-1:0] sd [2];
  logic sl [2];

  always @(negedge clk) begin
    logic v [2];
    logic rd [2];
    logic lst [2];
    logic emp [2];
    logic [DW-1:0] dat [2];
    logic [15:0] bc [2];
    int bl;
    v[0] = bus0.m_valid; rd[0] = bus0.fifo_rd_en; lst[0] = bus0.m_last;
    emp[0] = bus0.fifo_empty; dat[0] = bus0.m_data; bc[0] = bc0;
    v[1] = bus1.m_valid; rd[1] = bus1.fifo_rd_en; lst[1] = bus1.m_last;
    emp[1] = bus1.fifo_empty; dat[1] = bus1.m_data; bc[1] = bc1;
    for (int d = 0; d < 2; d++) begin
      bl = (d == 0) ? 4 : 1;
      if (rst) begin
        idx[d] = wr_ptr; beats[d] = 0; reads[d] = 0; pops[d] = 0; stall[d] = 1'b0;
      end else begin
        chk($sformatf("dut%0d_rd_en_on_empty", d), longint'(rd[d] && emp[d]), 0);
        chk($sformatf("dut%0d_outstanding_le2", d), longint'((reads[d] - pops[d]) <= 2), 1);
        chk($sformatf("dut%0d_m_last", d), longint'(lst[d]),
            longint'(v[d] && ((beats[d] % bl) == bl - 1)));
        chk($sformatf("dut%0d_burst_cnt", d), longint'(bc[d]), longint'((beats[d] / bl) % 65536));
        if (stall[d]) begin
          chk($sformatf("dut%0d_hold_valid", d), longint'(v[d]), 1);
          chk($sformatf("dut%0d_hold_data", d), longint'(dat[d]), longint'(sd[d]));
          chk($sformatf("dut%0d_hold_last", d), longint'(lst[d]), longint'(sl[d]));
        end
        if (v[d] && ready) begin
          chk($sformatf("dut%0d_data_order", d), longint'(dat[d]), longint'(mem[idx[d][7:0]]));
          idx[d]++; beats[d]++; pops[d]++;
        end
        if (rd[d]) reads[d]++;
        stall[d] = v[d] && !ready;
        sd[d] = dat[d];
        sl[d] = lst[d];
      end
    end
  end

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  logic [DW-1:0] gd [0:15];
  logic gl [0:15];
  int gc [0:15];
  int n, nrd;

  initial begin
    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_m_valid", bus0.m_valid, 0);
    chk("rst_m_data", bus0.m_data, 0);
    chk("rst_m_last", bus0.m_last, 0);
    chk("rst_burst_cnt", bc0, 0);
    chk("rst_rd_en", bus0.fifo_rd_en, 0);
    tick(); rst = 1'b0;

    // Streaming: 8 words, full rate.
    tick();
    for (int i = 0; i < 8; i++) push(DW'(32'h10 + i));
    ready = 1'b1; en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("stream_rd_en_c%0d", c), bus0.fifo_rd_en, longint'(c <= 7));
      chk($sformatf("stream_valid_c%0d", c), bus0.m_valid, longint'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk($sformatf("stream_data_c%0d", c), bus0.m_data, 32'h10 + c - 2);
      chk($sformatf("stream_last_c%0d", c), bus0.m_last, longint'(c == 5 || c == 9));
    end
    chk("stream_burst_cnt", bc0, 2);
    chk("stream_burst_cnt_bl1", bc1, 8);

    // Backpressure: 6 stalled cycles, then release.
    tick();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) push(DW'(32'h10 + i));
    nrd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus0.fifo_rd_en) nrd++;
      if (c >= 2) begin
        chk($sformatf("bp_valid_c%0d", c), bus0.m_valid, 1);
        chk($sformatf("bp_data_c%0d", c), bus0.m_data, 32'h10);
      end
    end
    chk("bp_reads_while_stalled", nrd, 2);
    tick();
    ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      chk($sformatf("bp_rel_valid_%0d", r), bus0.m_valid, 1);
      chk($sformatf("bp_rel_data_%0d", r), bus0.m_data, 32'h10 + r);
    end
    @(negedge clk);
    chk("bp_drained", bus0.m_valid, 0);
    chk("bp_burst_cnt", bc0, 4);

    // Underflow mid-burst.
    tick();
    push(32'h20); push(32'h21);
    n = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus0.m_valid && ready && n < 16) begin
        gd[n] = bus0.m_data; gl[n] = bus0.m_last; gc[n] = c; n++;
      end
      if (c == 4) begin
        tick();
        push(32'h22); push(32'h23);
      end
    end
    chk("uf_beats", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("uf_data_%0d", i), gd[i], 32'h20 + i);
      chk($sformatf("uf_last_%0d", i), gl[i], longint'(i == 3));
    end
    chk("uf_gap", longint'(gc[2] - gc[1] > 1), 1);
    chk("uf_burst_cnt", bc0, 5);

    // Enable gating: en high for the first two read cycles only.
    tick();
    en = 1'b0;
    for (int i = 0; i < 8; i++) push(DW'(32'h40 + i));
    tick();
    en = 1'b1;
    n = 0; nrd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus0.fifo_rd_en) nrd++;
      if (bus0.m_valid && ready && n < 16) begin
        gd[n] = bus0.m_data; gl[n] = bus0.m_last; gc[n] = c; n++;
      end
      if (c == 1) begin
        tick();
        en = 1'b0;
      end
    end
    chk("en_reads", nrd, 2);
    chk("en_beats", n, 2);
    chk("en_data_0", gd[0], 32'h40);
    chk("en_data_1", gd[1], 32'h41);
    tick();
    en = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus0.m_valid && ready && n < 16) begin
        gd[n] = bus0.m_data; gl[n] = bus0.m_last; gc[n] = c; n++;
      end
    end
    chk("en_resume_beats", n, 6);
    chk("en_resume_latency", gc[0], 2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("en_resume_data_%0d", i), gd[i], 32'h42 + i);
      chk($sformatf("en_resume_last_%0d", i), gl[i], longint'(i == 1 || i == 5));
    end
    chk("en_burst_cnt", bc0, 7);

    // Reset mid-operation with a full buffer.
    tick();
    en = 1'b0; ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'h60 + i));
    tick();
    en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("mid_full_valid", bus0.m_valid, 1);
    chk("mid_full_data", bus0.m_data, 32'h60);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus0.m_valid, 0);
    chk("mid_rst_last", bus0.m_last, 0);
    chk("mid_rst_rd_en", bus0.fifo_rd_en, 0);
    chk("mid_rst_burst_cnt", bc0, 0);
    chk("mid_rst_data", bus0.m_data, 0);
    push(32'h64);
    #1;
    chk("mid_rst_fifo_nonempty", bus0.fifo_empty, 0);
    chk("mid_rst_rd_en_gated", bus0.fifo_rd_en, 0);
    @(negedge clk);
    chk("mid_rst_rd_en_hold", bus0.fifo_rd_en, 0);
    tick(); tick();
    rst = 1'b0;

    // BURST_LEN=1 instance: every beat is last.
    tick();
    push(32'h50); push(32'h51); push(32'h52);
    ready = 1'b1; en = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus1.m_valid && ready && n < 16) begin
        gd[n] = bus1.m_data; gl[n] = bus1.m_last; n++;
      end
    end
    chk("bl1_beats", n, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bl1_data_%0d", i), gd[i], 32'h50 + i);
      chk($sformatf("bl1_last_%0d", i), gl[i], 1);
    end
    chk("bl1_burst_cnt", bc1, 3);
    chk("bl4_burst_cnt_after_3", bc0, 0);

    tick();
    summary();
    $finish;
  end
endmodule
